ahb_lite_master: RTL and testbench
==================================

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL provide HCLK, input, 1 -- single clock; all state updates on rising edge.
REQ-002 SHALL provide HRESET, input, 1 -- synchronous, active-high reset sampled on rising HCLK.
REQ-003 SHALL provide cmd_valid, input, 1 -- a local transfer request is present.
REQ-004 SHALL provide cmd_ready, output, 1 -- block accepts a request this cycle.
REQ-005 SHALL provide cmd_write, input, 1 -- 1 = write, 0 = read.
REQ-006 SHALL provide cmd_addr, input, 32 -- byte address of the request.
REQ-007 SHALL provide cmd_wdata, input, 64 -- write data.
REQ-008 SHALL provide rsp_valid, output, 1 -- one-cycle completion pulse.
REQ-009 SHALL provide rsp_error, output, 1 -- completion ended in error; valid with rsp_valid.
REQ-010 SHALL provide rsp_rdata, output, 64 -- read data; valid with rsp_valid on a successful read.
REQ-011 SHALL provide rsp_waits, output, 8 -- count of data-phase wait states; valid with rsp_valid.
REQ-012 SHALL provide HADDR (out, 32), HWRITE (out, 1), HTRANS (out, 2), HSIZE (out, 3), HBURST (out, 3), HPROT (out, 4), HMASTLOCK (out, 1), HWDATA (out, 64) -- AHB-Lite master outputs.
REQ-013 SHALL provide HREADY (in, 1), HRESP (in, 1), HRDATA (in, 64) -- AHB-Lite master inputs.

Function
REQ-014 SHALL drive constants HSIZE=3'b011, HBURST=3'b000 (SINGLE), HPROT=4'h1, HMASTLOCK=0, and issue only IDLE (2'b00) or NONSEQ (2'b10) on HTRANS.
REQ-015 SHALL implement FSM states IDLE, ADDR, DATA, ERR; cmd_ready=1 only in IDLE.
REQ-016 SHALL accept a command at an edge where cmd_valid=1 in IDLE; at most one transfer is outstanding.
REQ-017 SHALL reject misaligned commands (cmd_addr[2:0]!=0) in IDLE without bus activity: next cycle rsp_valid=1, rsp_error=1, rsp_waits=0, state stays IDLE.
REQ-018 SHALL, on an aligned accept, from the next cycle register HTRANS=NONSEQ, HADDR=cmd_addr, HWRITE=cmd_write, latch cmd_wdata, clear the wait counter, and enter ADDR.
REQ-019 SHALL hold the ADDR-phase outputs stable in ADDR until an edge sampling HREADY=1, then register HTRANS=IDLE, drive the latched data on HWDATA (writes), and enter DATA.
REQ-020 SHALL, in DATA: on HREADY=1 and HRESP=0, capture HRDATA into rsp_rdata (reads only) and pulse rsp_valid with rsp_error=0 next cycle; on HREADY=0 and HRESP=1, enter ERR; on HREADY=0 and HRESP=0, stay and count one wait.
REQ-021 SHALL, in ERR, wait for HREADY=1, then pulse rsp_valid with rsp_error=1, leaving rsp_rdata unchanged; HREADY=1 with HRESP=1 sampled in DATA is treated the same way.
REQ-022 SHALL return to IDLE on the edge producing rsp_valid, so a new command may be accepted in the rsp_valid cycle.
REQ-023 SHALL count every DATA/ERR cycle sampling HREADY=0 in rsp_waits, saturating at 255 with no wrap.
REQ-024 SHALL hold HWDATA and rsp_rdata at their last values when not updated; rsp_valid is never high two consecutive cycles for one transfer.

Reset
REQ-025 SHALL, while HRESET=1 at an edge, force state IDLE, HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, rsp_waits=0; constant outputs keep the REQ-014 values.
REQ-026 SHALL, on reset mid-transfer (ADDR/DATA/ERR), drop the transfer with no rsp_valid, and SHALL ignore cmd_valid during reset cycles.

Verification
REQ-027 Read, zero-wait: read addr 0x0000_0040; slave HREADY=1 and returns 64'hABCDEF1234567890 -> NONSEQ for 1 cycle, then rsp_valid=1, rsp_error=0, rsp_rdata=64'hABCDEF1234567890, rsp_waits=0.
REQ-028 Write, 3 waits: write addr 0x0000_0008, data 64'h1122334455667788; HREADY low for 3 data-phase cycles -> HWDATA stable through the data phase, rsp_valid with rsp_waits=3, rsp_error=0.
REQ-029 Error response: slave gives HRESP=1/HREADY=0, then HRESP=1/HREADY=1 -> state ERR for 1 cycle, rsp_valid=1, rsp_error=1, rsp_rdata unchanged.
REQ-030 Misaligned: cmd_addr=0x0000_0004 -> HTRANS stays IDLE, next cycle rsp_valid=1, rsp_error=1.
REQ-031 Saturation and back-to-back: read with 300 wait cycles -> rsp_waits=255; a command held valid during the rsp_valid cycle -> accepted that cycle, NONSEQ on the next cycle.
REQ-032 Reset in DATA: HRESET=1 for 1 cycle while waiting -> HTRANS=IDLE, no rsp_valid, cmd_ready=1 on the first cycle after reset.

Source files
------------

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: turns one local command at a time into a
// 64-bit SINGLE/NONSEQ bus transfer and reports status, read data and wait count.
// Ports: HCLK/HRESET (sync, active-high); cmd_* request side (cmd_ready only in IDLE);
//   rsp_* one-cycle completion pulse; H* AHB-Lite master outputs and slave inputs.
module ahb_lite_master (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [63:0] rsp_rdata,
  output logic [7:0]  rsp_waits,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [63:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] hwdata_q, hwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0]  waits_q, waits_d;
  logic [7:0]  waits_inc;
  logic        cmd_aligned;

  assign cmd_aligned = (cmd_addr[2:0] == 3'b000);
  // Wait counter sticks at 255 rather than wrapping.
  assign waits_inc   = (waits_q == 8'hFF) ? waits_q : waits_q + 8'd1;

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid && cmd_aligned) state_d = S_ADDR;
      S_ADDR: if (HREADY) state_d = S_DATA;
      // HREADY=1 completes (OK or error); a first-cycle error response parks in ERR.
      S_DATA: begin
        if (HREADY)     state_d = S_IDLE;
        else if (HRESP) state_d = S_ERR;
      end
      S_ERR:  if (HREADY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    wdata_d     = wdata_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;
    waits_d     = waits_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          waits_d = 8'd0;
          if (!cmd_aligned) begin
            // Misaligned: answer locally, never touch the bus.
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            htrans_d = TRANS_NONSEQ;
            haddr_d  = cmd_addr;
            hwrite_d = cmd_write;
            wdata_d  = cmd_wdata;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          htrans_d = TRANS_IDLE;
          if (hwrite_q) hwdata_d = wdata_q;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = HRESP;
          if (!HRESP && !hwrite_q) rsp_rdata_d = HRDATA;
        end else begin
          waits_d = waits_inc;
        end
      end
      S_ERR: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end else begin
          waits_d = waits_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      htrans_q    <= TRANS_IDLE;
      haddr_q     <= 32'd0;
      hwrite_q    <= 1'b0;
      wdata_q     <= 64'd0;
      hwdata_q    <= 64'd0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      waits_q     <= 8'd0;
    end else begin
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      wdata_q     <= wdata_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
      waits_q     <= waits_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_waits = waits_q;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HTRANS    = htrans_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = 3'b011;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'h1;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: directed transfers, expected responses queued at issue
// and checked by an independent monitor whenever rsp_valid is seen.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [63:0] rsp_rdata;
  logic [7:0]  rsp_waits;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [63:0] HWDATA;
  logic        HREADY, HRESP;
  logic [63:0] HRDATA;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .rsp_waits(rsp_waits),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        err;
    logic [7:0]  waits;
    logic [63:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          tests  = 0;
  int          failed = 0;
  logic [63:0] last_rdata = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rsp_valid pulse must match the oldest queued expectation.
  always @(negedge HCLK) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_error", 64'(rsp_error), 64'(e.err));
        check("rsp_waits", 64'(rsp_waits), 64'(e.waits));
        check("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // One aligned transfer starting in the current (IDLE or rsp_valid) cycle.
  // nwait plain wait states; err adds an HRESP=1/HREADY=0 cycle then HRESP=1/HREADY=1.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                      input int nwait, input logic err, input logic [63:0] rd);
    exp_t e;
    int   w;
    check("cmd_ready_at_issue", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    HREADY = 1'b1; HRESP = 1'b0;
    w = err ? nwait + 1 : nwait;
    e.err   = err;
    e.waits = (w > 255) ? 8'd255 : 8'(w);
    if (!wr && !err) last_rdata = rd;
    e.rdata = last_rdata;
    exp_q.push_back(e);
    step();
    cmd_valid = 1'b0;
    check("addr_htrans", 64'(HTRANS), 64'd2);
    check("addr_haddr", 64'(HADDR), 64'(addr));
    check("addr_hwrite", 64'(HWRITE), 64'(wr));
    step();
    check("data_htrans", 64'(HTRANS), 64'd0);
    if (wr) check("data_hwdata", HWDATA, wd);
    for (int i = 0; i < nwait; i++) begin
      HREADY = 1'b0; HRESP = 1'b0;
      step();
      if (wr) check("wait_hwdata", HWDATA, wd);
    end
    if (err) begin
      HREADY = 1'b0; HRESP = 1'b1;
      step();
      check("err_no_rsp", 64'(rsp_valid), 64'd0);
      HREADY = 1'b1; HRESP = 1'b1; HRDATA = 64'hDEAD_DEAD_DEAD_DEAD;
      step();
    end else begin
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = rd;
      step();
    end
    HRESP = 1'b0;
    HRDATA = 64'h0BAD_0BAD_0BAD_0BAD;
    // Now in the rsp_valid cycle.
    check("rsp_cycle_valid", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    exp_t e;
    int   guard;
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 32'd0; cmd_wdata = 64'd0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 64'd0;
    repeat (3) step();
    HRESET = 1'b0;

    // Reset state and constant outputs
    check("rst_htrans", 64'(HTRANS), 64'd0);
    check("rst_haddr", 64'(HADDR), 64'd0);
    check("rst_hwrite", 64'(HWRITE), 64'd0);
    check("rst_hwdata", HWDATA, 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_error", 64'(rsp_error), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_waits", 64'(rsp_waits), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("const_hsize", 64'(HSIZE), 64'd3);
    check("const_hburst", 64'(HBURST), 64'd0);
    check("const_hprot", 64'(HPROT), 64'd1);
    check("const_hmastlock", 64'(HMASTLOCK), 64'd0);
    step();

    // Zero-wait read
    xfer(1'b0, 32'h0000_0040, 64'd0, 0, 1'b0, 64'hABCDEF1234567890);
    step();
    // Write with 3 waits; rsp_rdata must hold the previous read data
    xfer(1'b1, 32'h0000_0008, 64'h1122334455667788, 3, 1'b0, 64'd0);
    step();
    // Error response: ERR for one cycle, one wait counted
    xfer(1'b0, 32'h0000_0100, 64'd0, 0, 1'b1, 64'd0);
    step();
    // Error after two plain waits
    xfer(1'b1, 32'h0000_0200, 64'hCAFE_F00D_0000_0001, 2, 1'b1, 64'd0);
    step();

    // Misaligned: no bus activity, error response next cycle
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0004;
    e.err = 1'b1; e.waits = 8'd0; e.rdata = last_rdata;
    exp_q.push_back(e);
    step();
    cmd_valid = 1'b0;
    check("misal_htrans", 64'(HTRANS), 64'd0);
    check("misal_cmd_ready", 64'(cmd_ready), 64'd1);
    check("misal_rsp_valid", 64'(rsp_valid), 64'd1);
    step();
    check("misal_htrans_after", 64'(HTRANS), 64'd0);

    // Saturating wait count, then a back-to-back command in the rsp_valid cycle
    xfer(1'b0, 32'h0000_0080, 64'd0, 300, 1'b0, 64'h0123_4567_89AB_CDEF);
    xfer(1'b0, 32'h0000_0088, 64'd0, 1, 1'b0, 64'h5555_AAAA_5555_AAAA);
    xfer(1'b1, 32'h0000_0090, 64'hFFFF_0000_FFFF_0000, 0, 1'b0, 64'd0);
    step();

    // Reset while waiting in DATA; cmd_valid during reset must be ignored
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0300;
    step();
    cmd_valid = 1'b0;
    check("rstx_nonseq", 64'(HTRANS), 64'd2);
    step();
    HREADY = 1'b0;
    step();
    step();
    HRESET = 1'b1; cmd_valid = 1'b1; cmd_addr = 32'h0000_0400;
    step();
    HRESET = 1'b0; cmd_valid = 1'b0; HREADY = 1'b1;
    last_rdata = 64'd0;
    check("rstx_htrans", 64'(HTRANS), 64'd0);
    check("rstx_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rstx_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rstx_haddr", 64'(HADDR), 64'd0);
    check("rstx_rdata", rsp_rdata, 64'd0);
    repeat (3) begin
      step();
      check("rstx_idle_htrans", 64'(HTRANS), 64'd0);
    end

    // Normal operation resumes
    xfer(1'b0, 32'h0000_0500, 64'd0, 2, 1'b0, 64'h7777_8888_9999_AAAA);
    step();

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL rsp_missing: got %0d responses outstanding, expected 0", exp_q.size());
    end
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
